// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hazard_pkg                                             |
// | Description : Shared constants for the D-stage hazard scoreboard:    |
// |               stall reason bit indices, CP0 register numbers, MDU    |
// |               latencies and Tnew/Tuse encodings used by control.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package hazard_pkg;

    // Bit positions inside stall_reason
    localparam int SR_DATA = 0;
    localparam int SR_MDU  = 1;
    localparam int SR_ERET = 2;

    // CP0 register numbers
    localparam int CP0_SR    = 12;
    localparam int CP0_CAUSE = 13;
    localparam int CP0_EPC   = 14;

    // Default multi-cycle MDU latencies
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Tuse: stages until the operand is consumed (0 = needed in D)
    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    // Tnew: stages until the result is forwardable, counted from E
    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Busy cycles loaded into the MDU counter for a started operation
    function automatic int mdu_latency(input logic is_div, input int mult_lat, input int div_lat);
        return is_div ? div_lat : mult_lat;
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sb_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sb_down_counter                                        |
// | Description : Saturating down-counter. Reset and clear beat load,    |
// |               load beats the decrement, and zero holds at zero.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sb_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear/reset first, then load, otherwise count down towards zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule : sb_down_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                      |
// | Description : D-stage stall unit built on a per-register countdown   |
// |               scoreboard, with MDU busy and EPC/eret interlocks and  |
// |               a saturating stalled-cycle counter.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int T_W      = 2,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int MDU_W    = 4,
    parameter int EPC_ADDR = CP0_EPC,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic [REG_AW-1:0] d_wdst,
    input  logic [T_W-1:0]    d_tnew,
    input  logic              d_md,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_mtc0,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_eret,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        stall_reason,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int c_NREG = 2 ** REG_AW;

    logic             w_rst;
    logic             w_issue;
    logic [T_W-1:0]   w_cnt [c_NREG];
    logic [MDU_W-1:0] w_mdu_cnt;
    logic [MDU_W-1:0] w_mdu_load_val;
    logic [1:0]       w_epc_pend;
    logic             w_epc_write;
    logic [2:0]       w_reason;
    logic [CNT_W-1:0] r_stall_count;

    assign w_rst   = ~reset;
    // A stalled or flushed D instruction leaves no trace in the scoreboard
    assign w_issue = d_valid & ~stall & ~flush;

    // $zero is never a real dependency, so its entry is hardwired clear
    assign w_cnt[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < c_NREG; gi++) begin : g_reg_cnt
            sb_down_counter #(.W(T_W)) u_cnt (
                .clk      (clk),
                .rst      (w_rst),
                .clr      (flush),
                .load     (w_issue && (d_wdst == REG_AW'(gi))),
                .load_val (d_tnew),
                .count    (w_cnt[gi])
            );
        end
    endgenerate

    // A flush does not cancel an MDU operation already in flight
    assign w_mdu_load_val = MDU_W'(mdu_latency(d_md_div, MULT_LAT, DIV_LAT));

    sb_down_counter #(.W(MDU_W)) u_mdu_cnt (
        .clk      (clk),
        .rst      (w_rst),
        .clr      (1'b0),
        .load     (w_issue & d_md_start),
        .load_val (w_mdu_load_val),
        .count    (w_mdu_cnt)
    );

    // EPC is written two stages after D (end of M), hence a count of two
    assign w_epc_write = w_issue & d_mtc0 & (d_rd == REG_AW'(EPC_ADDR));

    sb_down_counter #(.W(2)) u_epc_pend (
        .clk      (clk),
        .rst      (w_rst),
        .clr      (flush),
        .load     (w_epc_write),
        .load_val (2'd2),
        .count    (w_epc_pend)
    );

    // Collect the individual stall causes from current state and D fields
    always_comb begin
        w_reason          = '0;
        w_reason[SR_DATA] = ((d_rs != '0) && (w_cnt[d_rs] > d_tuse_rs)) ||
                            ((d_rt != '0) && (w_cnt[d_rt] > d_tuse_rt));
        w_reason[SR_MDU]  = d_md && (w_mdu_cnt != '0);
        w_reason[SR_ERET] = d_eret && (w_epc_pend != '0);
    end

    assign stall        = d_valid & (|w_reason);
    assign stall_reason = d_valid ? w_reason : 3'b000;
    assign mdu_busy     = (w_mdu_cnt != '0);

    // Count stalled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_hazard_scoreboard                                   |
// | Description : Directed vector bench for hazard_scoreboard.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_hazard_scoreboard;

    localparam int c_CNT_W = 4;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [4:0] rs;
        logic [1:0] tur;
        logic [4:0] rt;
        logic [1:0] tut;
        logic [4:0] wdst;
        logic [1:0] tnew;
        logic       md;
        logic       mds;
        logic       mdd;
        logic       mtc0;
        logic [4:0] rd;
        logic       eret;
        logic       flush;
        logic       exp_stall;
        logic [2:0] exp_reason;
        logic       exp_busy;
        string      name;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               d_valid;
    logic [4:0]         d_rs, d_rt, d_wdst, d_rd;
    logic [1:0]         d_tuse_rs, d_tuse_rt, d_tnew;
    logic               d_md, d_md_start, d_md_div, d_mtc0, d_eret, flush;
    logic               stall;
    logic [2:0]         stall_reason;
    logic               mdu_busy;
    logic [c_CNT_W-1:0] stall_count;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    int                 exp_sc  = 0;
    vec_t               vecs[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(c_CNT_W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_tuse_rs    (d_tuse_rs),
        .d_tuse_rt    (d_tuse_rt),
        .d_wdst       (d_wdst),
        .d_tnew       (d_tnew),
        .d_md         (d_md),
        .d_md_start   (d_md_start),
        .d_md_div     (d_md_div),
        .d_mtc0       (d_mtc0),
        .d_rd         (d_rd),
        .d_eret       (d_eret),
        .flush        (flush),
        .stall        (stall),
        .stall_reason (stall_reason),
        .mdu_busy     (mdu_busy),
        .stall_count  (stall_count)
    );

    // Valid instruction with given operand/destination fields, no side flags
    function automatic vec_t ins(input logic [4:0] rs, input logic [1:0] tur,
                                 input logic [4:0] rt, input logic [1:0] tut,
                                 input logic [4:0] wdst, input logic [1:0] tnew);
        vec_t v;
        v.rst_n = 1'b1; v.valid = 1'b1;
        v.rs = rs; v.tur = tur; v.rt = rt; v.tut = tut;
        v.wdst = wdst; v.tnew = tnew;
        v.md = 1'b0; v.mds = 1'b0; v.mdd = 1'b0;
        v.mtc0 = 1'b0; v.rd = '0; v.eret = 1'b0; v.flush = 1'b0;
        v.exp_stall = 1'b0; v.exp_reason = '0; v.exp_busy = 1'b0; v.name = "";
        return v;
    endfunction

    function automatic vec_t md_op(input logic start, input logic is_div);
        vec_t v;
        v = ins(0, 0, 0, 0, 0, 0);
        v.md = 1'b1; v.mds = start; v.mdd = is_div;
        return v;
    endfunction

    function automatic vec_t mtc0(input logic [4:0] rd);
        vec_t v;
        v = ins(0, 0, 0, 0, 0, 0);
        v.mtc0 = 1'b1; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t eret();
        vec_t v;
        v = ins(0, 0, 0, 0, 0, 0);
        v.eret = 1'b1;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic s, input logic [2:0] r,
                       input logic b, input string n);
        vec_t t;
        t = v;
        t.exp_stall = s; t.exp_reason = r; t.exp_busy = b; t.name = n;
        vecs.push_back(t);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Drive one cycle, check mid-cycle, then advance the stall counter model
    task automatic apply(input vec_t v);
        reset      = v.rst_n;  d_valid   = v.valid;
        d_rs       = v.rs;     d_tuse_rs = v.tur;
        d_rt       = v.rt;     d_tuse_rt = v.tut;
        d_wdst     = v.wdst;   d_tnew    = v.tnew;
        d_md       = v.md;     d_md_start = v.mds; d_md_div = v.mdd;
        d_mtc0     = v.mtc0;   d_rd      = v.rd;
        d_eret     = v.eret;   flush     = v.flush;
        @(negedge clk);
        check({v.name, ".stall"},  32'(stall),        32'(v.exp_stall));
        check({v.name, ".reason"}, 32'(stall_reason), 32'(v.exp_reason));
        check({v.name, ".busy"},   32'(mdu_busy),     32'(v.exp_busy));
        check({v.name, ".count"},  32'(stall_count),  32'(exp_sc));
        @(posedge clk);
        #1;
        if (!v.rst_n)                            exp_sc = 0;
        else if (v.exp_stall && exp_sc < 15)     exp_sc++;
    endtask

    initial begin
        vec_t v;

        // Bring state out of X before any check
        v = ins(0, 0, 0, 0, 0, 0);
        v.valid = 1'b0; v.rst_n = 1'b0;
        apply_raw: begin
            reset = 1'b0; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_wdst = '0; d_rd = '0;
            d_tuse_rs = '0; d_tuse_rt = '0; d_tnew = '0; d_md = 1'b0; d_md_start = 1'b0;
            d_md_div = 1'b0; d_mtc0 = 1'b0; d_eret = 1'b0; flush = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end

        add(v, 0, 3'b000, 0, "reset");
        // load-use: lw $1 then add rs=$1 tuse=1 -> one stall cycle
        add(ins(0, 0, 0, 0, 1, 2), 0, 3'b000, 0, "lw1");
        add(ins(1, 1, 0, 0, 4, 1), 1, 3'b001, 0, "lu_stall");
        add(ins(1, 1, 0, 0, 4, 1), 0, 3'b000, 0, "lu_go");
        // ALU result into branch: tuse=0 stalls, tuse=1 does not
        add(ins(4, 1, 0, 0, 2, 1), 0, 3'b000, 0, "add2");
        add(ins(2, 0, 0, 0, 0, 0), 1, 3'b001, 0, "beq_stall");
        add(ins(2, 0, 0, 0, 0, 0), 0, 3'b000, 0, "beq_go");
        add(ins(0, 0, 0, 0, 2, 1), 0, 3'b000, 0, "add2b");
        add(ins(2, 1, 2, 1, 0, 0), 0, 3'b000, 0, "tuse1_go");
        // writes to $0 are never recorded; reads of $0 never stall
        add(ins(0, 0, 0, 0, 0, 3), 0, 3'b000, 0, "w0");
        add(ins(0, 0, 0, 0, 0, 0), 0, 3'b000, 0, "r0");
        // rt path, two-cycle stall
        add(ins(0, 0, 0, 0, 6, 2), 0, 3'b000, 0, "lw6");
        add(ins(0, 0, 6, 0, 0, 0), 1, 3'b001, 0, "rt_st1");
        add(ins(0, 0, 6, 0, 0, 0), 1, 3'b001, 0, "rt_st2");
        add(ins(0, 0, 6, 0, 0, 0), 0, 3'b000, 0, "rt_go");
        // an invalid D slot never stalls but still lets counters drain
        add(ins(0, 0, 0, 0, 7, 2), 0, 3'b000, 0, "lw7");
        v = ins(7, 0, 0, 0, 0, 0); v.valid = 1'b0;
        add(v, 0, 3'b000, 0, "inval");
        add(ins(7, 0, 0, 0, 0, 0), 1, 3'b001, 0, "r7_st");
        add(ins(7, 0, 0, 0, 0, 0), 0, 3'b000, 0, "r7_go");
        // mult then mflo: 5 MDU stall cycles
        add(md_op(1, 0), 0, 3'b000, 0, "mult");
        for (int k = 0; k < 5; k++) add(md_op(0, 0), 1, 3'b010, 1, "mult_wait");
        add(md_op(0, 0), 0, 3'b000, 0, "mflo_go");
        // div then mflo: 10 MDU stall cycles
        add(md_op(1, 1), 0, 3'b000, 0, "div");
        for (int k = 0; k < 10; k++) add(md_op(0, 0), 1, 3'b010, 1, "div_wait");
        add(md_op(0, 0), 0, 3'b000, 0, "mflo_go2");
        // mtc0 EPC then eret: 2 stall cycles; mtc0 SR: none
        add(mtc0(14), 0, 3'b000, 0, "mtc0_epc");
        add(eret(), 1, 3'b100, 0, "eret_st1");
        add(eret(), 1, 3'b100, 0, "eret_st2");
        add(eret(), 0, 3'b000, 0, "eret_go");
        add(mtc0(12), 0, 3'b000, 0, "mtc0_sr");
        add(eret(), 0, 3'b000, 0, "eret_sr");
        // flush clears a pending load dependency
        add(ins(0, 0, 0, 0, 3, 2), 0, 3'b000, 0, "lw3");
        v = ins(3, 0, 0, 0, 0, 0); v.flush = 1'b1;
        add(v, 1, 3'b001, 0, "flush_dep");
        add(ins(3, 0, 0, 0, 0, 0), 0, 3'b000, 0, "after_flush");
        // issue coinciding with flush records nothing
        v = ins(0, 0, 0, 0, 3, 2); v.flush = 1'b1;
        add(v, 0, 3'b000, 0, "lw3_flushed");
        add(ins(3, 0, 0, 0, 0, 0), 0, 3'b000, 0, "no_rec");
        v = mtc0(14); v.flush = 1'b1;
        add(v, 0, 3'b000, 0, "mtc0_flushed");
        add(eret(), 0, 3'b000, 0, "eret_nrec");
        // flush clears epc_pend
        add(mtc0(14), 0, 3'b000, 0, "mtc0_epc2");
        v = eret(); v.flush = 1'b1;
        add(v, 1, 3'b100, 0, "eret_flush");
        add(eret(), 0, 3'b000, 0, "eret_clr");
        // flush does not cancel an MDU operation
        add(md_op(1, 0), 0, 3'b000, 0, "mult2");
        v = md_op(0, 0); v.flush = 1'b1;
        add(v, 1, 3'b010, 1, "mdu_flush");
        for (int k = 0; k < 4; k++) add(md_op(0, 0), 1, 3'b010, 1, "mdu_keep");
        add(md_op(0, 0), 0, 3'b000, 0, "mdu_done");
        // reset mid-div with a pending load
        add(md_op(1, 1), 0, 3'b000, 0, "div2");
        add(ins(0, 0, 0, 0, 8, 2), 0, 3'b000, 1, "lw8");
        v = md_op(0, 0); v.rs = 8; v.rst_n = 1'b0;
        add(v, 1, 3'b011, 1, "rst_mid");
        v = md_op(0, 0); v.rs = 8;
        add(v, 0, 3'b000, 0, "post_rst");
        // reset beats a same-cycle issue
        v = ins(0, 0, 0, 0, 9, 2); v.rst_n = 1'b0;
        add(v, 0, 3'b000, 0, "rst_issue");
        add(ins(9, 0, 0, 0, 0, 0), 0, 3'b000, 0, "rst_won");

        foreach (vecs[i]) apply(vecs[i]);

        // Stall counter saturation: 20 stalled cycles from zero end at 15
        v = ins(0, 0, 0, 0, 0, 0); v.valid = 1'b0; v.rst_n = 1'b0;
        v.name = "sat_rst";
        apply(v);
        for (int j = 0; j < 2; j++) begin
            v = md_op(1, 1); v.name = "sat_div";
            apply(v);
            for (int k = 0; k < 10; k++) begin
                v = md_op(0, 0); v.exp_stall = 1'b1; v.exp_reason = 3'b010;
                v.exp_busy = 1'b1; v.name = "sat_wait";
                apply(v);
            end
        end
        v = ins(0, 0, 0, 0, 0, 0); v.name = "sat_end";
        apply(v);
        check("sat_value", 32'(stall_count), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful successor to the D-stage stall unit of the five-stage MIPS pipeline.
- Replaces per-stage Tnew/Tuse comparison with a per-register countdown scoreboard.
- Adds a multi-cycle MDU busy interlock, a CP0 EPC-write/eret interlock and a saturating stall-cycle performance counter.
- Sits beside the D-stage decoder. Consumes decoded D-stage fields and drives the pipeline stall (freeze F/D, bubble into E).

Parameters:
- REG_AW, 5: register index width; scoreboard holds 2**REG_AW entries.
- T_W, 2: width of Tnew/Tuse fields and per-register counters.
- MULT_LAT, 5: MDU busy cycles loaded for mult/multu.
- DIV_LAT, 10: MDU busy cycles loaded for div/divu.
- MDU_W, 4: MDU busy counter width; must satisfy 2**MDU_W > max(MULT_LAT, DIV_LAT).
- EPC_ADDR, 14: CP0 register number of EPC.
- CNT_W, 16: stall_count width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- d_valid, in, 1: D stage holds a real instruction.
- d_rs, in, REG_AW: rs read index; 0 means not read.
- d_rt, in, REG_AW: rt read index; 0 means not read.
- d_tuse_rs, in, T_W: Tuse of rs.
- d_tuse_rt, in, T_W: Tuse of rt.
- d_wdst, in, REG_AW: GPR write destination; 0 means none.
- d_tnew, in, T_W: Tnew of the result once the instruction is in E.
- d_md, in, 1: instruction uses HI/LO/MDU (mult, div, mfhi, mflo, mthi, mtlo).
- d_md_start, in, 1: instruction starts an MDU operation.
- d_md_div, in, 1: the started operation is a divide.
- d_mtc0, in, 1: instruction is mtc0.
- d_rd, in, REG_AW: CP0 destination of mtc0.
- d_eret, in, 1: instruction is eret.
- flush, in, 1: exception/eret flush of E and M.
- stall, out, 1: freeze F/D and inject a bubble into E.
- stall_reason, out, 3: bit0 data, bit1 mdu, bit2 eret.
- mdu_busy, out, 1: MDU counter nonzero.
- stall_count, out, CNT_W: saturating count of stalled cycles.

Behaviour:
- Issue condition: issue = d_valid & ~stall & ~flush, sampled at the clock edge.
- State:
  - cnt[r], T_W bits per register.
  - mdu_cnt, MDU_W bits.
  - epc_pend, 2 bits.
  - stall_count.
  - All clear to 0 when reset=0 at a clock edge. Reset wins over every other event.
- Per-cycle update of cnt[r]: saturating decrement to 0, except:
  - If issue and d_wdst==r and r!=0, load d_tnew instead (issue beats decrement).
  - cnt[0] is always 0.
- Data stall, bit0 (combinational from current state):
  - (d_rs!=0 & cnt[d_rs] > d_tuse_rs) | (d_rt!=0 & cnt[d_rt] > d_tuse_rt).
  - This equals the E/M Tnew-vs-Tuse rule with forwarding. A bubble keeps counting down.
- MDU:
  - On issue & d_md_start, load mdu_cnt = d_md_div ? DIV_LAT : MULT_LAT.
  - Otherwise saturating decrement.
  - Stall bit1 = d_md & mdu_cnt!=0.
  - mdu_busy = (mdu_cnt != 0).
  - flush does not clear mdu_cnt: an already-started operation completes.
- EPC interlock:
  - On issue & d_mtc0 & d_rd==EPC_ADDR, load epc_pend = 2 (E, then M).
  - Otherwise saturating decrement.
  - Stall bit2 = d_eret & epc_pend!=0.
- Output gating: stall = d_valid & |reasons. stall_reason is likewise gated by d_valid. Both are 0 out of reset with d_valid=0.
- Flush:
  - Clears all cnt[] and epc_pend next cycle.
  - Suppresses issue, so nothing is recorded that cycle.
  - mdu_cnt still decrements.
- stall_count increments on each cycle with stall=1. It holds at all-ones and never wraps.
- WAW: a younger writer overwrites cnt[r]; no separate older-writer tracking.
- Latency: stall is purely combinational on D inputs and state. State takes effect the cycle after issue.

Decomposition:
- Shared package hazard_pkg holds:
  - stall_reason bit indices (SR_DATA=0, SR_MDU=1, SR_ERET=2).
  - CP0 register numbers (EPC=14, SR=12, CAUSE=13).
  - Default MULT_LAT/DIV_LAT.
  - Tnew/Tuse encodings shared with control.
- One natural sub-module, sb_down_counter (parametrised width): load-has-priority saturating down-counter with synchronous clear. It is instantiated per register, for mdu_cnt and for epc_pend.

Test Plan:
- lw $1 (d_wdst=1, d_tnew=2) issued, next cycle add using rs=1 with tuse=1 -> stall=1, stall_reason=001 for exactly 1 cycle, then stall=0.
- add $2 (tnew=1) issued, next cycle beq rs=2 tuse=0 -> 1-cycle stall. Same with tuse=1 -> no stall. rs=0 with cnt nonzero -> never stall.
- mult issued (MULT_LAT=5), mflo follows immediately -> stall_reason=010 for 5 cycles, mdu_busy falls with stall. Repeat with div -> 10 cycles.
- mtc0 rd=14 issued, eret next cycle -> stall 2 cycles (reason=100). mtc0 rd=12 -> no stall.
- lw $3 issued, then flush asserted with a dependent instruction in D -> cnt cleared, no stall the cycle after flush. Issue and flush in the same cycle records nothing.
- reset=0 asserted mid-div with pending cnt -> next cycle mdu_busy=0, stall_count=0, no stalls. stall_count with CNT_W=4 saturates at 15 after more than 15 stalled cycles.
